// File: rtl/uart_tx_serializer.sv
// RS-232 transmit serializer: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Every output comes from a flop so the line never glitches on state changes.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic [7:0] iData,
  input  logic       iTxSend,
  output logic       oTx,
  output logic       oTxBusy,
  output logic       oTxDone
);

  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic        ODD       = 1'(PARITY_ODD);
  localparam logic        HAS_PAR   = (PARITY_EN != 0);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic        r_stop;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        w_tick;

  assign w_tick = (r_baud == LAST_CNT);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      oTx     <= 1'b1;
      oTxBusy <= 1'b0;
      oTxDone <= 1'b0;
    end else begin
      oTxDone <= 1'b0;
      if (r_state != IDLE)
        r_baud <= w_tick ? '0 : r_baud + 16'd1;
      case (r_state)
        IDLE: begin
          oTx     <= 1'b1;
          oTxBusy <= 1'b0;
          if (iTxSend) begin
            // Parity is taken from the byte as accepted; later iData changes are irrelevant.
            r_shift <= iData;
            r_par   <= (^iData) ^ ODD;
            r_baud  <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            oTx     <= 1'b0;
            oTxBusy <= 1'b1;
            r_state <= START;
          end
        end
        START: if (w_tick) begin
          oTx     <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_bit   <= '0;
          r_state <= DATA;
        end
        DATA: if (w_tick) begin
          if (r_bit == 3'd7) begin
            if (HAS_PAR) begin
              oTx     <= r_par;
              r_state <= PARITY;
            end else begin
              oTx     <= 1'b1;
              r_state <= STOP;
            end
          end else begin
            r_bit   <= r_bit + 3'd1;
            oTx     <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        PARITY: if (w_tick) begin
          oTx     <= 1'b1;
          r_state <= STOP;
        end
        STOP: if (w_tick) begin
          if (r_stop == LAST_STOP) begin
            oTxBusy <= 1'b0;
            oTxDone <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_stop <= r_stop + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: three serializer configurations share one stimulus; each check
// compares {oTx, oTxBusy, oTxDone} of one instance against hand-derived frames.
module tb_uart_tx_serializer;

  logic       iClock = 1'b0;
  logic       iReset = 1'b1;
  logic [7:0] iData  = 8'h00;
  logic       iTxSend = 1'b0;
  logic [2:0] w_tx, w_busy, w_done;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 iClock = ~iClock;

  // 0: no parity, 1 stop   1: even parity, 2 stop   2: odd parity, 2 stop
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
    .iClock(iClock), .iReset(iReset), .iData(iData), .iTxSend(iTxSend),
    .oTx(w_tx[0]), .oTxBusy(w_busy[0]), .oTxDone(w_done[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_d1 (
    .iClock(iClock), .iReset(iReset), .iData(iData), .iTxSend(iTxSend),
    .oTx(w_tx[1]), .oTxBusy(w_busy[1]), .oTxDone(w_done[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_d2 (
    .iClock(iClock), .iReset(iReset), .iData(iData), .iTxSend(iTxSend),
    .oTx(w_tx[2]), .oTxBusy(w_busy[2]), .oTxDone(w_done[2]));

  function automatic logic [2:0] obs(input int sel);
    return {w_tx[sel], w_busy[sel], w_done[sel]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    iReset = 1'b1; iTxSend = 1'b0;
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
  endtask

  task automatic idle_chk(input int sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk(tag, obs(sel), 3'b100);
      @(negedge iClock);
    end
  endtask

  // Called at a negedge. Checks every cycle of one frame with 4 clocks per bit.
  // inj >= 0 pulses a 0xFF request mid-frame; keep leaves iTxSend high and
  // presents next_d in the done cycle so the next frame is accepted there.
  task automatic frame(input int sel, input logic [7:0] d, input int pen, input logic par,
                       input int nstop, input bit do_send, input int inj, input bit keep,
                       input logic [7:0] next_d, input string tag);
    int   nb;
    int   k;
    logic e;
    nb = 1 + 8 + pen + nstop;
    if (do_send) begin
      iData = d; iTxSend = 1'b1;
      @(negedge iClock);
    end
    if (!keep) iTxSend = 1'b0;
    for (int j = 0; j < nb * 4; j++) begin
      k = j / 4;
      if (k == 0)                  e = 1'b0;
      else if (k < 9)              e = d[k-1];
      else if (pen != 0 && k == 9) e = par;
      else                         e = 1'b1;
      chk($sformatf("%s_c%0d", tag, j), obs(sel), {e, 2'b10});
      if (j == inj) begin iData = 8'hFF; iTxSend = 1'b1; end
      else if (j == inj + 1) iTxSend = 1'b0;
      @(negedge iClock);
    end
    chk({tag, "_done"}, obs(sel), 3'b101);
    if (keep) iData = next_d;
    @(negedge iClock);
    if (!keep) chk({tag, "_after"}, obs(sel), 3'b100);
  endtask

  initial begin
    // reset state and quiet line
    do_reset();
    chk("rst_d0", obs(0), 3'b100);
    chk("rst_d1", obs(1), 3'b100);
    chk("rst_d2", obs(2), 3'b100);
    idle_chk(0, 20, "idle");

    // 0xA3 = bits LSB first 1,1,0,0,0,1,0,1 ; popcount 4
    frame(0, 8'hA3, 0, 1'b0, 1, 1'b1, -5, 1'b0, 8'h00, "a3");
    do_reset();
    frame(1, 8'hA3, 1, 1'b0, 2, 1'b1, -5, 1'b0, 8'h00, "a3_even");
    do_reset();
    frame(2, 8'hA3, 1, 1'b1, 2, 1'b1, -5, 1'b0, 8'h00, "a3_odd");

    // request while busy is dropped, no second frame or done
    do_reset();
    frame(0, 8'h55, 0, 1'b0, 1, 1'b1, 10, 1'b0, 8'h00, "busy_ign");
    idle_chk(0, 45, "busy_ign_idle");

    // send held high: frames follow with no gap after the done cycle
    do_reset();
    frame(0, 8'h00, 0, 1'b0, 1, 1'b1, -5, 1'b1, 8'hFF, "b2b_f1");
    frame(0, 8'hFF, 0, 1'b0, 1, 1'b0, -5, 1'b0, 8'h00, "b2b_f2");
    idle_chk(0, 10, "b2b_idle");

    // reset during data bit 3 (frame cycles 16..19) aborts without done
    do_reset();
    iData = 8'hA3; iTxSend = 1'b1;
    @(negedge iClock);
    iTxSend = 1'b0;
    repeat (17) @(negedge iClock);
    chk("abort_pre", obs(0), 3'b010);
    iReset = 1'b1;
    @(negedge iClock);
    chk("abort_rst", obs(0), 3'b100);
    iReset = 1'b0;
    idle_chk(0, 20, "abort_idle");
    // 0x3C = bits LSB first 0,0,1,1,1,1,0,0
    frame(0, 8'h3C, 0, 1'b0, 1, 1'b1, -5, 1'b0, 8'h00, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
